// File: rtl/cpu_pkg.sv
// Shared encodings for the simple-RISC controller: FSM states, opcodes,
// RAM commands and datapath select codes.
package cpu_pkg;

  typedef enum logic [4:0] {
    RST, IF1, IF2, UPD, DECODE, WIMM, GETA, GETB, EXEC, CMP, WRD,
    ADDR, LDADDR, MRD1, MRD2, GETRD, STC, MWR, HALT
  } state_t;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_t;

  // Instruction class latched at DECODE so shared states can branch on it.
  typedef enum logic [3:0] {
    I_NOP, I_MOVI, I_MOVR, I_MVN, I_ADD, I_AND, I_CMP, I_LDR, I_STR, I_HALT
  } inst_t;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;
  localparam logic [1:0] OP_MEM  = 2'b00;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b11;

  function automatic state_t first_state(input inst_t cls);
    case (cls)
      I_MOVI:                             return WIMM;
      I_MOVR, I_MVN:                      return GETB;
      I_ADD, I_AND, I_CMP, I_LDR, I_STR:  return GETA;
      I_HALT:                             return HALT;
      default:                            return IF1;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Maps the instruction register opcode/op fields to an instruction class and
// to the state that follows DECODE; unknown encodings fall back to NOP.
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output inst_t      cls,
  output state_t     next_state
);

  always_comb begin
    cls = I_NOP;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOVI)      cls = I_MOVI;
        else if (op == OP_MOVR) cls = I_MOVR;
      end
      OPC_ALU: begin
        case (op)
          OP_ADD:  cls = I_ADD;
          OP_CMP:  cls = I_CMP;
          OP_AND:  cls = I_AND;
          default: cls = I_MVN;
        endcase
      end
      OPC_LDR:  if (op == OP_MEM) cls = I_LDR;
      OPC_STR:  if (op == OP_MEM) cls = I_STR;
      OPC_HALT: cls = I_HALT;
      default:  cls = I_NOP;
    endcase
    next_state = first_state(cls);
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Moore control FSM for the simple-RISC datapath: fetch, PC update, decode,
// then the per-instruction execute sequence; parks in HALT until reset.
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       reset_pc,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic [2:0] nsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       halted
);

  state_t   state, state_next;
  inst_t    cls, cls_dec;
  state_t   dec_next;
  mem_cmd_t mc;

  cpu_ctrl_decode u_decode (
    .opcode     (opcode),
    .op         (op),
    .cls        (cls_dec),
    .next_state (dec_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST;
      cls   <= I_NOP;
    end else begin
      state <= state_next;
      if (state == DECODE) cls <= cls_dec;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RST:    state_next = IF1;
      IF1:    state_next = IF2;
      IF2:    state_next = UPD;
      UPD:    state_next = DECODE;
      DECODE: state_next = dec_next;
      WIMM:   state_next = IF1;
      GETA:   state_next = (cls == I_LDR || cls == I_STR) ? ADDR : GETB;
      GETB:   state_next = (cls == I_CMP) ? CMP : EXEC;
      EXEC:   state_next = WRD;
      CMP:    state_next = IF1;
      WRD:    state_next = IF1;
      ADDR:   state_next = LDADDR;
      LDADDR: state_next = (cls == I_LDR) ? MRD1 : GETRD;
      MRD1:   state_next = MRD2;
      MRD2:   state_next = IF1;
      GETRD:  state_next = STC;
      STC:    state_next = MWR;
      MWR:    state_next = IF1;
      HALT:   state_next = HALT;
      default: state_next = RST;
    endcase
  end

  always_comb begin
    reset_pc  = 1'b0;
    load_pc   = 1'b0;
    load_ir   = 1'b0;
    load_addr = 1'b0;
    addr_sel  = 1'b0;
    mc        = MNONE;
    nsel      = NSEL_NONE;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = VSEL_MDATA;
    halted    = 1'b0;
    case (state)
      RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      IF1: begin
        addr_sel = 1'b1;
        mc       = MREAD;
      end
      IF2: begin
        addr_sel = 1'b1;
        mc       = MREAD;
        load_ir  = 1'b1;
      end
      UPD:  load_pc = 1'b1;
      WIMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      GETA: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      GETB: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      // Single-operand ops (MOV reg, MVN) force A to zero.
      EXEC: begin
        loadc = 1'b1;
        asel  = (cls == I_MOVR || cls == I_MVN);
      end
      CMP:  loads = 1'b1;
      WRD: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      LDADDR: load_addr = 1'b1;
      MRD1:   mc = MREAD;
      MRD2: begin
        mc    = MREAD;
        nsel  = NSEL_RD;
        vsel  = VSEL_MDATA;
        write = 1'b1;
      end
      GETRD: begin
        nsel  = NSEL_RD;
        loadb = 1'b1;
      end
      STC: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      MWR:  mc = MWRITE;
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign mem_cmd = mc;

endmodule
